stopwatch_bcd: RTL and testbench

- Counts seconds as a 4-digit BCD MM:SS stopwatch (00:00 to 59:59).
- Its time base is the 1 Hz divided square wave from the clock divider stage, on `tick_in`.
- Sits directly downstream of the divider; both blocks run on the board clock.
- Provides start/stop/clear control, a wrap pulse, and an optional multiplexed seven-segment driver.

---
 rtl/stopwatch_bcd.sv | 188 ++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch counting synchronized 1 Hz ticks with start/stop/clear control.
// Define STOPWATCH_SEG7_EN to build the multiplexed active-low seven-segment driver.
module stopwatch_bcd #(
    parameter int SYNC_STAGES = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       inclk,
    input  logic       inrst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap,
    output logic [6:0] seg,
    output logic [3:0] an
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // Per-digit roll-over limits, index 0 = sec_ones.
    localparam logic [3:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

    generate
        if (SYNC_STAGES < 2 || REFRESH_DIV < 1) begin : g_param_check
            $error("stopwatch_bcd: SYNC_STAGES must be >= 2 and REFRESH_DIV >= 1");
        end
    endgenerate

    logic [2:0] async_in;
    logic [2:0] pulse;
    logic       tick_p;
    logic       ss_p;
    logic       clr_p;

    assign async_in = {clear, start_stop, tick_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   edge_reg;

            always_ff @(posedge inclk or negedge inrst_n) begin
                if (!inrst_n) begin
                    sync_reg <= '0;
                    edge_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
                    edge_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            assign pulse[gi] = sync_reg[SYNC_STAGES-1] & ~edge_reg;
        end
    endgenerate

    assign tick_p = pulse[0];
    assign ss_p   = pulse[1];
    assign clr_p  = pulse[2];

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr_p) begin
            state_next = IDLE;
        end else if (ss_p) begin
            unique case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_reg == RUN);
    end

    logic [3:0][3:0] digit_reg;
    logic [3:0][3:0] digit_next;
    logic            wrap_reg;
    logic            wrap_next;

    // Ripple the carry through the digits; a carry out of min_tens is the wrap.
    always_comb begin
        logic carry;
        digit_next = digit_reg;
        wrap_next  = 1'b0;
        carry      = 1'b0;
        if (clr_p) begin
            digit_next = '0;
        end else if (tick_p && state_reg == RUN) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (digit_reg[i] >= DIGIT_MAX[i]) begin
                        digit_next[i] = 4'd0;
                    end else begin
                        digit_next[i] = digit_reg[i] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
            wrap_next = carry;
        end
    end

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            digit_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            digit_reg <= digit_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign sec_ones = digit_reg[0];
    assign sec_tens = digit_reg[1];
    assign min_ones = digit_reg[2];
    assign min_tens = digit_reg[3];
    assign wrap     = wrap_reg;

`ifdef STOPWATCH_SEG7_EN
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    logic [RW-1:0] refresh_reg;
    logic [1:0]    idx_reg;
    logic [6:0]    seg_reg;
    logic [3:0]    an_reg;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            refresh_reg <= '0;
            idx_reg     <= 2'd0;
            seg_reg     <= 7'b1000000;
            an_reg      <= 4'b1110;
        end else begin
            if (refresh_reg == REFRESH_LAST) begin
                refresh_reg <= '0;
                idx_reg     <= idx_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            seg_reg <= bcd_to_seg(digit_reg[idx_reg]);
            an_reg  <= ~(4'b0001 << idx_reg);
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
`else
    assign seg = 7'b1111111;
    assign an  = 4'b1111;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd: latency, carry/wrap, control priority,
// asynchronous reset and the segment outputs for whichever build is compiled.
module tb_stopwatch_bcd;

    logic       inclk;
    logic       inrst_n;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;
    logic [6:0] seg;
    logic [3:0] an;
    logic [15:0] bcd;

    int checks   = 0;
    int failures = 0;

`ifdef STOPWATCH_SEG7_EN
    localparam logic [6:0] SEG_RST = 7'b1000000;
    localparam logic [3:0] AN_RST  = 4'b1110;
`else
    localparam logic [6:0] SEG_RST = 7'b1111111;
    localparam logic [3:0] AN_RST  = 4'b1111;
`endif

    stopwatch_bcd #(
        .SYNC_STAGES(2),
        .REFRESH_DIV(4)
    ) dut (
        .inclk      (inclk),
        .inrst_n    (inrst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap),
        .seg        (seg),
        .an         (an)
    );

    assign bcd = {min_tens, min_ones, sec_tens, sec_ones};

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    // Raise the selected inputs together, hold 4 cycles high and 4 low.
    task automatic press(input logic t, input logic s, input logic c);
        @(posedge inclk);
        #1;
        tick_in    = t;
        start_stop = s;
        clear      = c;
        repeat (4) @(posedge inclk);
        #1;
        tick_in    = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        repeat (4) @(posedge inclk);
        @(negedge inclk);
    endtask

    // One tick with the count checked one edge before and at the edge it must land on.
    task automatic timed_tick(input int before_s);
        @(posedge inclk);
        #1 tick_in = 1'b1;
        @(posedge inclk);
        @(posedge inclk);
        @(negedge inclk);
        check("lat_before", bcd, to_bcd(before_s));
        @(posedge inclk);
        @(negedge inclk);
        check("lat_after", bcd, to_bcd(before_s + 1));
        tick_in = 1'b0;
        repeat (4) @(posedge inclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"}, bcd, 16'h0000);
        check({tag, "_running"}, running, 1'b0);
        check({tag, "_wrap"}, wrap, 1'b0);
        check({tag, "_seg"}, seg, SEG_RST);
        check({tag, "_an"}, an, AN_RST);
    endtask

    initial begin
        logic [3:0] an_seq [4];
        logic [3:0] prev_an;
        bit         found;

        an_seq[0] = 4'b1110;
        an_seq[1] = 4'b1101;
        an_seq[2] = 4'b1011;
        an_seq[3] = 4'b0111;

        inrst_n    = 1'b0;
        tick_in    = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        repeat (3) @(posedge inclk);
        @(negedge inclk);
        check_reset_outputs("rst");
        @(posedge inclk);
        #1 inrst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            @(negedge inclk);
            if (i % 100 == 99) begin
                check("idle_bcd", bcd, 16'h0000);
                check("idle_running", running, 1'b0);
                check("idle_wrap", wrap, 1'b0);
            end
        end

        press(1'b0, 1'b1, 1'b0);
        check("start_running", running, 1'b1);
        for (int i = 0; i < 75; i++) timed_tick(i);
        check("m0115_bcd", bcd, 16'h0115);
        check("m0115_running", running, 1'b1);

        for (int i = 75; i < 3598; i++) press(1'b1, 1'b0, 1'b0);
        check("m5958_bcd", bcd, 16'h5958);
        press(1'b1, 1'b0, 1'b0);
        check("m5959_bcd", bcd, 16'h5959);

        @(posedge inclk);
        #1 tick_in = 1'b1;
        @(posedge inclk);
        @(posedge inclk);
        @(negedge inclk);
        check("wrap_pre_bcd", bcd, 16'h5959);
        check("wrap_pre", wrap, 1'b0);
        @(posedge inclk);
        @(negedge inclk);
        check("wrap_bcd", bcd, 16'h0000);
        check("wrap_pulse", wrap, 1'b1);
        check("wrap_running", running, 1'b1);
        @(posedge inclk);
        @(negedge inclk);
        check("wrap_post", wrap, 1'b0);
        check("wrap_post_bcd", bcd, 16'h0000);
        tick_in = 1'b0;
        repeat (4) @(posedge inclk);

        for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0);
        check("m0010_bcd", bcd, 16'h0010);
        press(1'b0, 1'b1, 1'b0);
        check("pause_running", running, 1'b0);
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        check("pause_hold_bcd", bcd, 16'h0010);
        press(1'b1, 1'b1, 1'b0);
        check("resume_tick_bcd", bcd, 16'h0010);
        check("resume_running", running, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        check("m0011_bcd", bcd, 16'h0011);
        press(1'b1, 1'b1, 1'b0);
        check("stop_tick_bcd", bcd, 16'h0012);
        check("stop_running", running, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("rerun_running", running, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        check("clr_tick_bcd", bcd, 16'h0000);
        check("clr_running", running, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        check("clr_ss_running", running, 1'b0);

        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 754; i++) press(1'b1, 1'b0, 1'b0);
        check("m1234_bcd", bcd, 16'h1234);
        check("m1234_running", running, 1'b1);
        @(posedge inclk);
        #3 inrst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (3) @(posedge inclk);
        #1 inrst_n = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        check("post_rst_bcd", bcd, 16'h0000);

        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("m0007_bcd", bcd, 16'h0007);
`ifdef STOPWATCH_SEG7_EN
        found = 1'b0;
        @(negedge inclk);
        prev_an = an;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge inclk);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
            else prev_an = an;
        end
        check("seg_align", found, 1'b1);
        if (found) begin
            for (int j = 0; j < 16; j++) begin
                if (j > 0) @(negedge inclk);
                check("seg_an", an, an_seq[(j / 4) % 4]);
                check("seg_seg", seg, (j < 4) ? 7'b1111000 : 7'b1000000);
            end
        end
`else
        found   = 1'b0;
        prev_an = 4'b0000;
        for (int j = 0; j < 16; j++) begin
            @(negedge inclk);
            check("seg_off", seg, 7'b1111111);
            check("an_off", an, 4'b1111);
        end
        check("seg_off_unused", {found, prev_an}, 5'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
